// File: rtl/chunk_packer_hs.sv
// chunk_packer_hs: packs GRAN-aligned chunks LSB-first into wide words
// with valid/ready output, input backpressure, flush and length checking.
module chunk_packer_hs #(
   parameter int WIDTH_IN  = 64,
   parameter int WIDTH_OUT = 272,
   parameter int GRAN      = 16,
   parameter int LEN_W     = 9,
   parameter int FILL_W    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [WIDTH_IN-1:0]  din,
   input  logic [LEN_W-1:0]     len,
   input  logic                 inv,
   output logic                 din_ready,
   input  logic                 flush,
   output logic [WIDTH_OUT-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [FILL_W-1:0]    fill,
   output logic                 err
);

   localparam int AW = WIDTH_OUT + WIDTH_IN;
   localparam logic [FILL_W-1:0] WO_F = FILL_W'(WIDTH_OUT);
   localparam logic [LEN_W-1:0]  WI_L = LEN_W'(WIDTH_IN);
   localparam logic [LEN_W-1:0]  GR_L = LEN_W'(GRAN);

   logic [AW-1:0]       acc;
   logic [AW-1:0]       acc_n;
   logic [AW-1:0]       base_acc;
   logic [FILL_W-1:0]   fill_n;
   logic [FILL_W-1:0]   base_fill;
   logic [WIDTH_IN-1:0] mask;
   logic [WIDTH_IN-1:0] chunk;
   logic                flush_pend;
   logic                xfer;
   logic                accept;
   logic                legal;

   assign xfer = ((fill >= WO_F) | (flush_pend & (fill != '0)))
               & (~dout_valid | dout_ready);

   assign din_ready = ~flush_pend & ((fill < WO_F) | xfer);
   assign accept    = ce & din_ready;
   assign legal     = (len != '0) & (len <= WI_L)
                    & ((len % GR_L) == '0);

   // next accumulator: shift out a word first, then append the chunk
   always_comb begin
      mask = '1;
      mask = mask >> (WI_L - len);
      if (inv) chunk = din >> (WI_L - len);
      else     chunk = din & mask;
      if (xfer) begin
         base_acc  = acc >> WIDTH_OUT;
         base_fill = (fill > WO_F) ? fill - WO_F : '0;
      end else begin
         base_acc  = acc;
         base_fill = fill;
      end
      acc_n  = base_acc;
      fill_n = base_fill;
      if (accept & legal) begin
         acc_n  = base_acc
                | ({{WIDTH_OUT{1'b0}}, chunk} << base_fill);
         fill_n = base_fill + FILL_W'(len);
      end
   end

   // state, output word register and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         fill       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         flush_pend <= 1'b0;
         err        <= 1'b0;
      end else begin
         acc  <= acc_n;
         fill <= fill_n;
         if (accept & (len != '0) & ~legal)
            err <= 1'b1;
         if (xfer) begin
            dout       <= acc[WIDTH_OUT-1:0];
            dout_valid <= 1'b1;
         end else if (dout_valid & dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (flush)
            flush_pend <= 1'b1;
         else if (fill_n == '0)
            flush_pend <= 1'b0;
      end
   end

endmodule
